// File: rtl/control_unit_if.sv
// Bundles the sequencer's imem, regfile and ALU signals; master is the control unit,
// slave is the memory/regfile/ALU side.
interface control_unit_if #(
   parameter int PC_W   = 8,
   parameter int DATA_W = 8
);
   logic [PC_W-1:0]   o_IMem_Addr;
   logic              o_IMem_Req;
   logic              i_IMem_Valid;
   logic [15:0]       i_IMem_Data;
   logic [1:0]        o_Rd_Addr_1;
   logic [1:0]        o_Rd_Addr_2;
   logic [DATA_W-1:0] i_Rd_Data_1;
   logic [DATA_W-1:0] i_Rd_Data_2;
   logic [2:0]        o_ALU_Op;
   logic [DATA_W-1:0] o_ALU_Val_1;
   logic [DATA_W-1:0] o_ALU_Val_2;
   logic [DATA_W-1:0] i_ALU_Result;
   logic              i_ALU_Overflow;
   logic              i_ALU_Zero;
   logic              o_Wr_En;
   logic [1:0]        o_Wr_Addr;
   logic [DATA_W-1:0] o_Wr_Data;
   logic              o_Flag_Z;
   logic              o_Flag_V;
   logic              o_Halted;
   logic              o_Illegal;

   // Fetch handshake: o_IMem_Req is held with o_IMem_Addr stable until an edge
   // where i_IMem_Valid=1 and o_IMem_Req=1; valid at any other time is ignored.
   modport master (
      output o_IMem_Addr, o_IMem_Req, o_Rd_Addr_1, o_Rd_Addr_2, o_ALU_Op,
             o_ALU_Val_1, o_ALU_Val_2, o_Wr_En, o_Wr_Addr, o_Wr_Data,
             o_Flag_Z, o_Flag_V, o_Halted, o_Illegal,
      input  i_IMem_Valid, i_IMem_Data, i_Rd_Data_1, i_Rd_Data_2,
             i_ALU_Result, i_ALU_Overflow, i_ALU_Zero
   );

   modport slave (
      input  o_IMem_Addr, o_IMem_Req, o_Rd_Addr_1, o_Rd_Addr_2, o_ALU_Op,
             o_ALU_Val_1, o_ALU_Val_2, o_Wr_En, o_Wr_Addr, o_Wr_Data,
             o_Flag_Z, o_Flag_V, o_Halted, o_Illegal,
      output i_IMem_Valid, i_IMem_Data, i_Rd_Data_1, i_Rd_Data_2,
             i_ALU_Result, i_ALU_Overflow, i_ALU_Zero
   );
endinterface

// File: rtl/control_unit.sv
// MiniRISC fetch/decode/execute/writeback sequencer; sole driver of the ALU op code.
// FSM state is visible on o_Dbg_State.
module control_unit #(
   parameter int PC_W   = 8,
   parameter int DATA_W = 8
) (
   input  logic          i_Clk,
   input  logic          i_Rst,
   control_unit_if.master bus,
   output logic [2:0]    o_Dbg_State
);
   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_WRITEBACK = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_LDI  = 4'h3;
   localparam logic [3:0] OP_JMP  = 4'h4;
   localparam logic [3:0] OP_BZ   = 4'h5;
   localparam logic [3:0] OP_BV   = 4'h6;
   localparam logic [3:0] OP_HALT = 4'h7;

   state_t            r_state;
   state_t            w_next_state;
   logic [PC_W-1:0]   r_pc;
   logic [15:0]       r_ir;
   logic              r_flag_z;
   logic              r_flag_v;
   logic [DATA_W-1:0] r_val_1;
   logic [DATA_W-1:0] r_val_2;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_started;

   logic [3:0]        w_opcode;
   logic [PC_W-1:0]   w_imm_pc;
   logic [PC_W-1:0]   w_pc_next;
   logic              w_pc_load;
   logic              w_ir_load;
   logic              w_op_load;
   logic              w_res_load;
   logic              w_ldi_load;
   logic [2:0]        w_alu_op;
   logic              w_wr_en;
   logic              w_req;
   logic              w_illegal;
   logic              w_halted;

   assign w_opcode = r_ir[15:12];
   assign w_imm_pc = PC_W'(r_ir[7:0]);

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) r_state <= S_FETCH;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_pc_next    = r_pc + PC_W'(1);
      w_pc_load    = 1'b0;
      w_ir_load    = 1'b0;
      w_op_load    = 1'b0;
      w_res_load   = 1'b0;
      w_ldi_load   = 1'b0;
      w_alu_op     = 3'b000;
      w_wr_en      = 1'b0;
      w_req        = 1'b0;
      w_illegal    = 1'b0;
      w_halted     = 1'b0;
      case (r_state)
         S_FETCH: begin
            // r_started keeps the request low for the first cycle after reset release
            w_req = r_started;
            if (r_started && bus.i_IMem_Valid) begin
               w_ir_load    = 1'b1;
               w_next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            w_next_state = S_FETCH;
            case (w_opcode)
               OP_ADD, OP_SUB: begin
                  w_op_load    = 1'b1;
                  w_next_state = S_EXECUTE;
               end
               OP_LDI: begin
                  w_ldi_load   = 1'b1;
                  w_next_state = S_WRITEBACK;
               end
               OP_JMP: begin
                  w_pc_next = w_imm_pc;
                  w_pc_load = 1'b1;
               end
               OP_BZ: begin
                  if (r_flag_z) w_pc_next = w_imm_pc;
                  w_pc_load = 1'b1;
               end
               OP_BV: begin
                  if (r_flag_v) w_pc_next = w_imm_pc;
                  w_pc_load = 1'b1;
               end
               OP_HALT: w_next_state = S_HALT;
               OP_NOP:  w_pc_load = 1'b1;
               default: begin
                  w_illegal = 1'b1;
                  w_pc_load = 1'b1;
               end
            endcase
         end
         S_EXECUTE: begin
            w_alu_op     = (w_opcode == OP_SUB) ? 3'b010 : 3'b001;
            w_res_load   = 1'b1;
            w_next_state = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            w_wr_en      = 1'b1;
            w_pc_load    = 1'b1;
            w_next_state = S_FETCH;
         end
         S_HALT: w_halted = 1'b1;
         default: w_next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_pc      <= '0;
         r_ir      <= '0;
         r_flag_z  <= 1'b0;
         r_flag_v  <= 1'b0;
         r_val_1   <= '0;
         r_val_2   <= '0;
         r_wr_data <= '0;
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
         if (w_ir_load) r_ir <= bus.i_IMem_Data;
         if (w_pc_load) r_pc <= w_pc_next;
         if (w_op_load) begin
            r_val_1 <= bus.i_Rd_Data_1;
            r_val_2 <= bus.i_Rd_Data_2;
         end
         // Write data is staged here so writeback needs no mux on the opcode
         if (w_ldi_load) r_wr_data <= DATA_W'(r_ir[7:0]);
         if (w_res_load) begin
            r_wr_data <= bus.i_ALU_Result;
            r_flag_z  <= bus.i_ALU_Zero;
            r_flag_v  <= bus.i_ALU_Overflow;
         end
      end
   end

   assign bus.o_IMem_Addr = r_pc;
   assign bus.o_IMem_Req  = w_req;
   assign bus.o_Rd_Addr_1 = r_ir[9:8];
   assign bus.o_Rd_Addr_2 = r_ir[7:6];
   assign bus.o_ALU_Op    = w_alu_op;
   assign bus.o_ALU_Val_1 = r_val_1;
   assign bus.o_ALU_Val_2 = r_val_2;
   assign bus.o_Wr_En     = w_wr_en;
   assign bus.o_Wr_Addr   = r_ir[11:10];
   assign bus.o_Wr_Data   = r_wr_data;
   assign bus.o_Flag_Z    = r_flag_z;
   assign bus.o_Flag_V    = r_flag_v;
   assign bus.o_Halted    = w_halted;
   assign bus.o_Illegal   = w_illegal;
   assign o_Dbg_State     = r_state;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a program of table vectors plus hand-written
// reset, halt and late-valid sequences.
module tb_control_unit;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;
   logic [7:0] rf [4];
   int         n_checks = 0;
   int         n_fail   = 0;

   control_unit_if #(.PC_W(8), .DATA_W(8)) bus ();

   control_unit #(.PC_W(8), .DATA_W(8)) dut (
      .i_Clk      (clk),
      .i_Rst      (rst),
      .bus        (bus),
      .o_Dbg_State(dbg_state)
   );

   always #5 clk = ~clk;

   // Environment: combinational regfile read, ALU model, regfile write port
   assign bus.i_Rd_Data_1 = rf[bus.o_Rd_Addr_1];
   assign bus.i_Rd_Data_2 = rf[bus.o_Rd_Addr_2];

   logic [7:0] alu_a, alu_b, alu_r;
   always_comb begin
      alu_a = bus.o_ALU_Val_1;
      alu_b = bus.o_ALU_Val_2;
      alu_r = (bus.o_ALU_Op == 3'b010) ? alu_a - alu_b : alu_a + alu_b;
      bus.i_ALU_Result = alu_r;
      bus.i_ALU_Zero   = (alu_r == 8'h00);
      if (bus.o_ALU_Op == 3'b010)
         bus.i_ALU_Overflow = (alu_a[7] != alu_b[7]) && (alu_r[7] != alu_a[7]);
      else
         bus.i_ALU_Overflow = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      end else if (bus.o_Wr_En) begin
         rf[bus.o_Wr_Addr] <= bus.o_Wr_Data;
      end
   end

   typedef struct {
      logic [15:0] instr;
      int          dly;
      bit          spur;
      bit          exp_wr;
      logic [1:0]  exp_wa;
      logic [7:0]  exp_wd;
      logic        exp_z;
      logic        exp_v;
      logic [2:0]  exp_op;
      int          exp_ill;
      int          exp_lat;
      logic [7:0]  exp_pc;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic [15:0] instr, input int dly, input bit spur,
                               input bit wr, input logic [1:0] wa, input logic [7:0] wd,
                               input logic z, input logic v, input logic [2:0] op,
                               input int ill, input int lat, input logic [7:0] pc);
      vec_t r;
      r.instr = instr;  r.dly = dly;     r.spur = spur;
      r.exp_wr = wr;    r.exp_wa = wa;   r.exp_wd = wd;
      r.exp_z = z;      r.exp_v = v;     r.exp_op = op;
      r.exp_ill = ill;  r.exp_lat = lat; r.exp_pc = pc;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string p);
      chk({p, "_req"},     32'(bus.o_IMem_Req), 0);
      chk({p, "_addr"},    32'(bus.o_IMem_Addr), 0);
      chk({p, "_wr_en"},   32'(bus.o_Wr_En), 0);
      chk({p, "_alu_op"},  32'(bus.o_ALU_Op), 0);
      chk({p, "_flags"},   32'({bus.o_Flag_Z, bus.o_Flag_V}), 0);
      chk({p, "_halted"},  32'(bus.o_Halted), 0);
      chk({p, "_illegal"}, 32'(bus.o_Illegal), 0);
      chk({p, "_data"},    32'({bus.o_Wr_Data, bus.o_ALU_Val_1, bus.o_ALU_Val_2}), 0);
      chk({p, "_addrs"},   32'({bus.o_Rd_Addr_1, bus.o_Rd_Addr_2, bus.o_Wr_Addr}), 0);
      chk({p, "_state"},   32'(dbg_state), 0);
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.o_IMem_Req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      bit         ok;
      int         lat, wr_cnt, op_cnt, ill_cnt, stable_err;
      logic [7:0] addr0, wd;
      logic [1:0] wa;
      logic [2:0] opv;
      lat = 0; wr_cnt = 0; op_cnt = 0; ill_cnt = 0; stable_err = 0;
      wd = 8'h00; wa = 2'd0; opv = 3'd0;
      wait_req(ok);
      chk($sformatf("v%0d_req_wait", idx), 32'(ok), 1);
      addr0 = bus.o_IMem_Addr;
      for (int d = 0; d < v.dly; d++) begin
         if (!bus.o_IMem_Req || bus.o_IMem_Addr !== addr0) stable_err++;
         @(negedge clk);
      end
      if (!bus.o_IMem_Req || bus.o_IMem_Addr !== addr0) stable_err++;
      bus.i_IMem_Valid = 1'b1;
      bus.i_IMem_Data  = v.instr;
      @(negedge clk);
      for (int k = 1; k <= 8; k++) begin
         if (v.spur && k == 2) begin
            bus.i_IMem_Valid = 1'b1;
            bus.i_IMem_Data  = 16'h7000;
         end else begin
            bus.i_IMem_Valid = 1'b0;
         end
         if (bus.o_Wr_En) begin
            wr_cnt++;
            wa = bus.o_Wr_Addr;
            wd = bus.o_Wr_Data;
         end
         if (bus.o_ALU_Op != 3'b000) begin
            op_cnt++;
            opv = bus.o_ALU_Op;
         end
         if (bus.o_Illegal) ill_cnt++;
         if (bus.o_IMem_Req) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_next_pc", idx), 32'(bus.o_IMem_Addr), 32'(v.exp_pc));
      chk($sformatf("v%0d_wr_count", idx), 32'(wr_cnt), 32'(v.exp_wr));
      if (v.exp_wr) begin
         chk($sformatf("v%0d_wr_addr", idx), 32'(wa), 32'(v.exp_wa));
         chk($sformatf("v%0d_wr_data", idx), 32'(wd), 32'(v.exp_wd));
      end
      chk($sformatf("v%0d_flag_z", idx), 32'(bus.o_Flag_Z), 32'(v.exp_z));
      chk($sformatf("v%0d_flag_v", idx), 32'(bus.o_Flag_V), 32'(v.exp_v));
      chk($sformatf("v%0d_alu_cycles", idx), 32'(op_cnt), (v.exp_op != 3'b000) ? 1 : 0);
      if (v.exp_op != 3'b000) chk($sformatf("v%0d_alu_op", idx), 32'(opv), 32'(v.exp_op));
      chk($sformatf("v%0d_illegal", idx), 32'(ill_cnt), 32'(v.exp_ill));
      if (v.dly > 0) chk($sformatf("v%0d_fetch_stable", idx), 32'(stable_err), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int err;
      vec_t v_ldi, v_nop;
      rst = 1'b1;
      bus.i_IMem_Valid = 1'b0;
      bus.i_IMem_Data  = 16'h0000;

      //            instr     dly spur wr  wa    wd     z     v     op      ill lat pc
      vecs[0]  = mk(16'h347F, 0, 0, 1, 2'd1, 8'h7F, 1'b0, 1'b0, 3'b000, 0, 3, 8'h01);
      vecs[1]  = mk(16'h3801, 0, 0, 1, 2'd2, 8'h01, 1'b0, 1'b0, 3'b000, 0, 3, 8'h02);
      vecs[2]  = mk(16'h1D80, 0, 0, 1, 2'd3, 8'h80, 1'b0, 1'b1, 3'b001, 0, 4, 8'h03);
      vecs[3]  = mk(16'h3405, 0, 0, 1, 2'd1, 8'h05, 1'b0, 1'b1, 3'b000, 0, 3, 8'h04);
      vecs[4]  = mk(16'h2D40, 5, 1, 1, 2'd3, 8'h00, 1'b1, 1'b0, 3'b010, 0, 4, 8'h05);
      vecs[5]  = mk(16'h5020, 0, 0, 0, 2'd0, 8'h00, 1'b1, 1'b0, 3'b000, 0, 2, 8'h20);
      vecs[6]  = mk(16'h6040, 0, 0, 0, 2'd0, 8'h00, 1'b1, 1'b0, 3'b000, 0, 2, 8'h21);
      vecs[7]  = mk(16'h40FF, 0, 0, 0, 2'd0, 8'h00, 1'b1, 1'b0, 3'b000, 0, 2, 8'hFF);
      vecs[8]  = mk(16'h0000, 0, 0, 0, 2'd0, 8'h00, 1'b1, 1'b0, 3'b000, 0, 2, 8'h00);
      vecs[9]  = mk(16'hA123, 0, 0, 0, 2'd0, 8'h00, 1'b1, 1'b0, 3'b000, 1, 2, 8'h01);
      vecs[10] = mk(16'h2240, 0, 0, 1, 2'd0, 8'hFC, 1'b0, 1'b0, 3'b010, 0, 4, 8'h02);
      vecs[11] = mk(16'h3080, 0, 0, 1, 2'd0, 8'h80, 1'b0, 1'b0, 3'b000, 0, 3, 8'h03);
      vecs[12] = mk(16'h2480, 0, 0, 1, 2'd1, 8'h7F, 1'b0, 1'b1, 3'b010, 0, 4, 8'h04);
      vecs[13] = mk(16'h6003, 0, 0, 0, 2'd0, 8'h00, 1'b0, 1'b1, 3'b000, 0, 2, 8'h03);
      v_ldi    = mk(16'h3855, 0, 0, 1, 2'd2, 8'h55, 1'b0, 1'b0, 3'b000, 0, 3, 8'h01);
      v_nop    = mk(16'h0000, 0, 0, 0, 2'd0, 8'h00, 1'b0, 1'b0, 3'b000, 0, 2, 8'h01);

      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      #1;
      chk("req_low_before_first_edge", 32'(bus.o_IMem_Req), 0);
      @(negedge clk);
      chk("req_after_release", 32'(bus.o_IMem_Req), 1);
      chk("pc_after_release", 32'(bus.o_IMem_Addr), 0);

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // HALT at address 3, stray valids while halted
      wait_req(ok);
      chk("halt_req_wait", 32'(ok), 1);
      chk("halt_addr", 32'(bus.o_IMem_Addr), 32'h03);
      bus.i_IMem_Valid = 1'b1;
      bus.i_IMem_Data  = 16'h7000;
      @(negedge clk);
      bus.i_IMem_Valid = 1'b0;
      chk("halt_decode_req", 32'(bus.o_IMem_Req), 0);
      err = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.i_IMem_Valid = c[0];
         bus.i_IMem_Data  = 16'h1D80;
         if (!bus.o_Halted || bus.o_IMem_Req || bus.o_Wr_En) err++;
      end
      bus.i_IMem_Valid = 1'b0;
      chk("halt_hold_errors", 32'(err), 0);
      chk("halt_state", 32'(dbg_state), 4);

      // Async reset out of HALT, with a late valid held across release
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("rst_from_halt");
      bus.i_IMem_Valid = 1'b1;
      bus.i_IMem_Data  = 16'h7000;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("late_valid_state", 32'(dbg_state), 0);
      chk("late_valid_req", 32'(bus.o_IMem_Req), 1);
      bus.i_IMem_Valid = 1'b0;
      run_vec(v_ldi, 20);

      // Reset in the middle of an outstanding fetch at PC=1
      repeat (3) @(negedge clk);
      chk("midfetch_req_before", 32'(bus.o_IMem_Req), 1);
      #2 rst = 1'b1;
      #1;
      chk("midfetch_req_drop", 32'(bus.o_IMem_Req), 0);
      chk("midfetch_pc_zero", 32'(bus.o_IMem_Addr), 0);
      chk("midfetch_wr_en", 32'(bus.o_Wr_En), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_req", 32'(bus.o_IMem_Req), 1);
      chk("restart_pc", 32'(bus.o_IMem_Addr), 0);
      run_vec(v_nop, 21);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
